// File: rtl/mux_stim_pkg.sv
// mux_stim_pkg: shared state type, default timing constants and error-counter sizing
// for the 2:1 mux stimulus generator.
package mux_stim_pkg;
    typedef enum logic [1:0] {IDLE, SEL0, SEL1, DONE} state_e;
    localparam int HALF_PERIOD_DEF = 50;
    localparam int A_CYCLES_DEF = 1;
    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mux_stim_gen_if.sv
// mux_stim_gen_if: control, stimulus and feedback signals between the generator (master)
// and the mux/checking environment (slave).
interface mux_stim_gen_if;
    import mux_stim_pkg::*;
    logic start, stop, loop_en, q_in, s, busy, done;
    logic [1:0] a;
    logic [ERR_W-1:0] err_cnt;
    modport master(input start, stop, loop_en, q_in, output a, s, busy, done, err_cnt);
    modport slave(output start, stop, loop_en, q_in, input a, s, busy, done, err_cnt);
endinterface

// File: rtl/mux_stim_checker.sv
// mux_stim_checker: counts busy cycles where the mux output disagrees with S ? A[1] : A[0],
// saturating at the counter maximum; clr restarts the count at the beginning of a run.
module mux_stim_checker
    import mux_stim_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             busy_i,
    input  logic [1:0]       a_i,
    input  logic             s_i,
    input  logic             q_in_i,
    output logic [ERR_W-1:0] err_cnt_o
);
    logic [ERR_W-1:0] err_q;
    logic miss;
    assign miss = busy_i && q_in_i != (s_i ? a_i[1] : a_i[0]);
    always_ff @(posedge clk)
        err_q <= rst || clr_i ? '0 : miss && err_q != ERR_MAX ? err_q + 1'b1 : err_q;
    assign err_cnt_o = err_q;
endmodule

// File: rtl/mux_stim_gen.sv
// mux_stim_gen: sweeps A through 00..11 with S=0 then S=1, optionally looping.
// Define MUX_STIM_CHECK_EN to count mux output mismatches in err_cnt.
module mux_stim_gen
    import mux_stim_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int A_CYCLES = A_CYCLES_DEF
) (
    input logic            clk,
    input logic            rst,
    mux_stim_gen_if.master stim_io
);
    localparam int TW = cnt_w(HALF_PERIOD);
    localparam int SW = cnt_w(A_CYCLES);
    state_e state_q;
    logic [TW-1:0] tick_q;
    logic [SW-1:0] sweep_q;
    logic [1:0] a_q;
    logic s_q, busy_q, done_q;
    logic tick_end, wrap, phase_end, accept;
    assign tick_end = tick_q == TW'(HALF_PERIOD - 1);
    assign wrap = tick_end && a_q == 2'd3;
    assign phase_end = wrap && sweep_q == SW'(A_CYCLES - 1);
    assign accept = state_q == IDLE && stim_io.start && !stim_io.stop;
    // stop shares the reset path: it must beat start and any phase change
    always_ff @(posedge clk) begin
        if (rst || stim_io.stop) begin
            state_q <= IDLE;
            tick_q <= '0;
            sweep_q <= '0;
            a_q <= 2'd0;
            s_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= SEL0;
                    tick_q <= '0;
                    sweep_q <= '0;
                    a_q <= 2'd0;
                    s_q <= 1'b0;
                    busy_q <= 1'b1;
                end
                SEL0, SEL1: begin
                    tick_q <= tick_end ? '0 : tick_q + 1'b1;
                    a_q <= tick_end ? a_q + 2'd1 : a_q;
                    sweep_q <= phase_end ? '0 : wrap ? sweep_q + 1'b1 : sweep_q;
                    if (phase_end) begin
                        if (state_q == SEL0) begin
                            state_q <= SEL1;
                            s_q <= 1'b1;
                        end else if (stim_io.loop_en) begin
                            state_q <= SEL0;
                            s_q <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            s_q <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign stim_io.a = a_q;
    assign stim_io.s = s_q;
    assign stim_io.busy = busy_q;
    assign stim_io.done = done_q;
`ifdef MUX_STIM_CHECK_EN
    mux_stim_checker u_checker (
        .clk(clk),
        .rst(rst),
        .clr_i(accept),
        .busy_i(busy_q),
        .a_i(a_q),
        .s_i(s_q),
        .q_in_i(stim_io.q_in),
        .err_cnt_o(stim_io.err_cnt)
    );
`else
    logic unused_q_in;
    assign unused_q_in = stim_io.q_in;
    assign stim_io.err_cnt = '0;
`endif
endmodule

// File: tb/tb_mux_stim_gen.sv
// tb_mux_stim_gen: two generators (default timing and HALF_PERIOD=2/A_CYCLES=2) checked
// every cycle against a cycle-count model of the sweep, with randomized control timing.
module tb_mux_stim_gen;
    import mux_stim_pkg::*;
    localparam int HP0 = 50, AC0 = 1, HP1 = 2, AC1 = 2;
    localparam int P0 = 4 * HP0 * AC0, P1 = 4 * HP1 * AC1;
`ifdef MUX_STIM_CHECK_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0;
    int qm0 = 0, qm1 = 0;
    int mode[2], n[2], err[2], bcnt[2], dcnt[2];
    always #5 clk = ~clk;
    mux_stim_gen_if b0(), b1();
    mux_stim_gen #(.HALF_PERIOD(HP0), .A_CYCLES(AC0)) u0 (.clk(clk), .rst(rst), .stim_io(b0.master));
    mux_stim_gen #(.HALF_PERIOD(HP1), .A_CYCLES(AC1)) u1 (.clk(clk), .rst(rst), .stim_io(b1.master));
    function automatic logic feed(int qm, logic [1:0] a, logic s);
        return qm == 1 ? 1'b0 : qm == 2 ? !(s ? a[1] : a[0]) : (s ? a[1] : a[0]);
    endfunction
    assign b0.q_in = feed(qm0, b0.a, b0.s);
    assign b1.q_in = feed(qm1, b1.a, b1.s);
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask
    // run model: mode 0 idle, 1 running (n = cycles since start), 2 done pulse
    function automatic int exp_a(int i, int hp);
        return mode[i] == 1 ? ((n[i] - 1) / hp) % 4 : 0;
    endfunction
    function automatic int exp_s(int i, int p);
        return mode[i] == 1 ? ((n[i] - 1) / p) % 2 : 0;
    endfunction
    task automatic adv(int i, int hp, int p, logic rs, logic st, logic sp, logic lp, int qm);
        int ea, es, bv;
        bit mism;
        ea = exp_a(i, hp);
        es = exp_s(i, p);
        bv = es == 1 ? ea / 2 : ea % 2;
        mism = mode[i] == 1 && (qm == 2 || (qm == 1 && bv == 1));
        if (rs) err[i] = 0;
        else if (mode[i] == 0 && st && !sp) err[i] = 0;
        else if (mism && err[i] < 255) err[i]++;
        if (!CK) err[i] = 0;
        if (rs || sp) begin
            mode[i] = 0;
            n[i] = 0;
        end else if (mode[i] == 0) begin
            if (st) begin
                mode[i] = 1;
                n[i] = 1;
            end
        end else if (mode[i] == 2) mode[i] = 0;
        else if (n[i] % p == 0 && ((n[i] - 1) / p) % 2 == 1 && !lp) begin
            mode[i] = 2;
            n[i] = 0;
        end else n[i]++;
    endtask
    task automatic cmp(int i, int hp, int p, logic [1:0] a, logic s, logic bz, logic dn, logic [7:0] ec);
        chk($sformatf("u%0d.a", i), a, exp_a(i, hp));
        chk($sformatf("u%0d.s", i), s, exp_s(i, p));
        chk($sformatf("u%0d.busy", i), bz, mode[i] == 1);
        chk($sformatf("u%0d.done", i), dn, mode[i] == 2);
        chk($sformatf("u%0d.err_cnt", i), ec, err[i]);
        bcnt[i] += int'(bz);
        dcnt[i] += int'(dn);
    endtask
    task automatic cyc();
        adv(0, HP0, P0, rst, b0.start, b0.stop, b0.loop_en, qm0);
        adv(1, HP1, P1, rst, b1.start, b1.stop, b1.loop_en, qm1);
        @(posedge clk);
        #1;
        cmp(0, HP0, P0, b0.a, b0.s, b0.busy, b0.done, b0.err_cnt);
        cmp(1, HP1, P1, b1.a, b1.s, b1.busy, b1.done, b1.err_cnt);
    endtask
    task automatic go0();
        b0.start = 1'b1;
        cyc();
        b0.start = 1'b0;
    endtask
    task automatic go1();
        b1.start = 1'b1;
        cyc();
        b1.start = 1'b0;
    endtask
    task automatic gap();
        repeat ($urandom_range(1, 5)) cyc();
    endtask
    initial begin
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; n[i] = 0; err[i] = 0; bcnt[i] = 0; dcnt[i] = 0;
        end
        {b0.start, b0.stop, b0.loop_en, b1.start, b1.stop, b1.loop_en} = '0;
        repeat (3) cyc();
        rst = 1'b0;
        gap();
        // full default run with stray start pulses during SEL0
        bcnt[0] = 0; dcnt[0] = 0;
        go0();
        for (int i = 0; i < 410; i++) begin
            b0.start = mode[0] == 1 && n[0] < P0 && $urandom_range(0, 7) == 0;
            cyc();
        end
        b0.start = 1'b0;
        chk("u0.busy_len", bcnt[0], 2 * P0);
        chk("u0.done_cnt", dcnt[0], 1);
        // start together with stop in IDLE is ignored
        b0.start = 1'b1; b0.stop = 1'b1;
        cyc();
        b0.start = 1'b0; b0.stop = 1'b0;
        repeat (3) cyc();
        // looping run, then drop loop_en
        b1.loop_en = 1'b1; dcnt[1] = 0;
        go1();
        repeat (5 * P1 + $urandom_range(0, P1 - 1)) cyc();
        chk("u1.no_done_loop", dcnt[1], 0);
        b1.loop_en = 1'b0;
        repeat (2 * P1 + 4) cyc();
        chk("u1.done_once", dcnt[1], 1);
        gap();
        // stop on the SEL1 terminal cycle while looping
        b1.loop_en = 1'b1; dcnt[1] = 0;
        go1();
        repeat (2 * P1 - 1) cyc();
        b1.stop = 1'b1;
        cyc();
        b1.stop = 1'b0; b1.loop_en = 1'b0;
        chk("u1.stop_busy", b1.busy, 0);
        repeat (4) cyc();
        chk("u1.stop_no_done", dcnt[1], 0);
        // stop on the SEL0->SEL1 boundary, then at a random SEL1 cycle
        dcnt[0] = 0;
        go0();
        repeat (P0 - 1) cyc();
        b0.stop = 1'b1;
        cyc();
        b0.stop = 1'b0;
        gap();
        go0();
        repeat (P0 + $urandom_range(0, P0 - 1)) cyc();
        b0.stop = 1'b1;
        cyc();
        b0.stop = 1'b0;
        repeat (3) cyc();
        chk("u0.stop_no_done", dcnt[0], 0);
        // reset at cycle 123 of a run, then a complete run
        go0();
        repeat (122) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("u0.rst_a", b0.a, 0);
        bcnt[0] = 0; dcnt[0] = 0;
        go0();
        repeat (405) cyc();
        chk("u0.rst_busy_len", bcnt[0], 2 * P0);
        chk("u0.rst_done_cnt", dcnt[0], 1);
        // q_in stuck at 0: one error per expected-1 cycle
        qm0 = 1;
        go0();
        repeat (405) cyc();
        chk("u0.err_q0", b0.err_cnt, CK ? P0 : 0);
        repeat (5) cyc();
        chk("u0.err_hold", b0.err_cnt, CK ? P0 : 0);
        qm0 = 0;
        go0();
        repeat (405) cyc();
        chk("u0.err_clean", b0.err_cnt, 0);
        // inverted feedback while looping saturates the counter
        qm1 = 2; b1.loop_en = 1'b1;
        go1();
        repeat (300) cyc();
        chk("u1.err_sat", b1.err_cnt, CK ? 255 : 0);
        b1.stop = 1'b1;
        cyc();
        b1.stop = 1'b0; b1.loop_en = 1'b0; qm1 = 0;
        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_stim_gen.md
# mux_stim_gen

Clocked stimulus sequencer that drives the data (`A[1:0]`) and select (`S`) inputs of the 2:1 lab multiplexer (`mux_21_by_case`) directly upstream of it. It replaces hand-timed testbench waveforms with a synthesizable generator, so the same pattern runs in simulation and on the board. On `start`, it sweeps both data bits through all four combinations with `S=0`, repeats the sweep with `S=1`, then either stops or loops. An optional checker compares the mux output against the expected value.

## Interface
- `HALF_PERIOD`, default 50: `clk` cycles per `A[0]` half-period; legal minimum is 1.
- `A_CYCLES`, default 1: full 4-step `A` sweeps per select phase; legal minimum is 1.
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: one-cycle request to begin a run; honoured only in IDLE.
- `stop`, input, 1: abort; returns the block to IDLE.
- `loop_en`, input, 1: when 1, SEL1 wraps to SEL0 instead of ending the run.
- `A`, output, 2: mux data inputs; registered.
- `S`, output, 1: mux select; registered.
- `busy`, output, 1: high in SEL0 and SEL1.
- `done`, output, 1: one-cycle pulse in the DONE state.
- `q_in`, input, 1: mux output `Q`, fed back for checking.
- `err_cnt`, output, 8: count of checker mismatches.

## Operation
- FSM states are IDLE, SEL0, SEL1, DONE.
- Reset values: state IDLE, `A=00`, `S=0`, `busy=0`, `done=0`, `err_cnt=0`, all internal counters 0.
- IDLE → SEL0 on `start && !stop`. On entry, the tick counter and `A` are cleared.
- In SEL0 and SEL1:
  - The tick counter counts 0..HALF_PERIOD-1.
  - At its terminal count, `A` increments modulo 4. As a result, `A[0]` toggles every HALF_PERIOD cycles and `A[1]` every 2·HALF_PERIOD cycles.
  - A sweep counter counts the 3→0 wraps of `A`.
- Each select phase lasts exactly 4·HALF_PERIOD·A_CYCLES cycles.
- SEL0 → SEL1 after A_CYCLES wraps; `S` becomes 1. `A` is already 00 because of the wrap.
- SEL1 → SEL0 (with `S=0`) if `loop_en` is 1 at the transition cycle; otherwise SEL1 → DONE.
- In DONE: `A=00`, `S=0`, `done=1` for one cycle, then → IDLE.
- `stop` in any state: next state is IDLE; `A`, `S` and counters are cleared. `stop` wins over `start` and over any phase transition in the same cycle.
- `start` outside IDLE is ignored.
- `loop_en` is sampled only at the SEL1 terminal cycle.
- `rst` mid-run gives the reset values on the next edge, regardless of `stop` or `start`.

## Timing
- With `start` sampled high at edge k:
  - SEL0, `busy=1`, `A=00`, `S=0` from edge k+1.
  - First `A` change at edge k+1+HALF_PERIOD.
- With defaults, relative to edge k:
  - SEL0 occupies k+1..k+200.
  - SEL1 occupies k+201..k+400.
  - DONE (`done=1`) at k+401.
  - IDLE at k+402.
- `A` and `S` change only on the same edge as the corresponding state or tick event; there are no glitches.

## Configuration
- Macro `MUX_STIM_CHECK_EN`.
- Defined:
  - Each busy cycle, `expected = S ? A[1] : A[0]` is compared with `q_in`. The mux is combinational, so the comparison happens in the same cycle.
  - A mismatch increments `err_cnt` one cycle later, saturating at 255.
  - `err_cnt` is cleared on the cycle `start` is accepted. It holds its value in DONE and IDLE.
- Undefined: `q_in` is ignored and `err_cnt` is constant 0. Ports are unchanged.

## Structure
- Package `mux_stim_pkg` holds:
  - the state enum (IDLE/SEL0/SEL1/DONE);
  - default constants for HALF_PERIOD and A_CYCLES;
  - the `err_cnt` width (8) and its saturation value.
- Counter widths are derived with `$clog2` from the parameters.
- One sub-module, `mux_stim_checker`: takes `busy`, `A`, `S`, `q_in`, a clear input, and `clk`/`rst`, and produces `err_cnt`. It is instantiated only under `MUX_STIM_CHECK_EN`.

## Test plan
- Reset, then `start` with defaults:
  - `A` sequence 00,01,10,11 with each value held 50 cycles.
  - `S=0` for 200 cycles, then `S=1` for 200 cycles.
  - `done` at k+401.
  - `busy` falls at k+401.
- `loop_en=1` with HALF_PERIOD=2, A_CYCLES=2:
  - Phases of 16 cycles alternate S=0/1.
  - No `done` pulse.
  - Drop `loop_en`: the run ends after the current SEL1 with `done` exactly once.
- `stop` asserted in mid-SEL1 together with a phase boundary: IDLE next cycle, `A=00`, `S=0`, no `done`.
- `start` pulses during SEL0, and `start`+`stop` together in IDLE: both ignored, and the state timeline is unchanged.
- `rst` asserted at cycle 123 of a run: all outputs at reset values next edge. A subsequent `start` runs the full 401-cycle sequence.
- With `MUX_STIM_CHECK_EN`:
  - Real mux feedback: `err_cnt=0`.
  - `q_in` forced to 0: `err_cnt` equals the number of expected-1 cycles, which is 200 with defaults.
  - Looping with `q_in` inverted: `err_cnt` saturates at 255.
